// File: rtl/image_gaussian3x3_pkg.sv
// image_gaussian3x3_pkg: widths, kernel weights and pixel/window types
// shared by the 3x3 Gaussian smoothing stage.
package image_gaussian3x3_pkg;

  localparam int PIX_W  = 8;
  localparam int KSUM_W = 12;
  localparam int KSHIFT = 4;

  localparam logic [KSUM_W-1:0] K_CORNER = 12'd1;
  localparam logic [KSUM_W-1:0] K_EDGE   = 12'd2;
  localparam logic [KSUM_W-1:0] K_CENTRE = 12'd4;

  typedef enum logic {
    S_RUN,
    S_FLUSH
  } state_t;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } pix_t;

  typedef struct packed {
    pix_t top;
    pix_t mid;
    pix_t bot;
  } col_t;

  function automatic logic [PIX_W-1:0] gauss(
    input logic [PIX_W-1:0] p00, p01, p02,
    input logic [PIX_W-1:0] p10, p11, p12,
    input logic [PIX_W-1:0] p20, p21, p22
  );
    logic [KSUM_W-1:0] s;
    s = K_CORNER * KSUM_W'(p00) + K_EDGE * KSUM_W'(p01)
      + K_CORNER * KSUM_W'(p02) + K_EDGE * KSUM_W'(p10)
      + K_CENTRE * KSUM_W'(p11) + K_EDGE * KSUM_W'(p12)
      + K_CORNER * KSUM_W'(p20) + K_EDGE * KSUM_W'(p21)
      + K_CORNER * KSUM_W'(p22);
    return s[KSUM_W-1:KSHIFT];
  endfunction

  // a = left column, b = centre column, c = right column
  function automatic pix_t gauss_pix(input col_t a, input col_t b,
                                     input col_t c);
    pix_t o;
    o.r = gauss(a.top.r, b.top.r, c.top.r,
                a.mid.r, b.mid.r, c.mid.r,
                a.bot.r, b.bot.r, c.bot.r);
    o.g = gauss(a.top.g, b.top.g, c.top.g,
                a.mid.g, b.mid.g, c.mid.g,
                a.bot.g, b.bot.g, c.bot.g);
    o.b = gauss(a.top.b, b.top.b, c.top.b,
                a.mid.b, b.mid.b, c.mid.b,
                a.bot.b, b.bot.b, c.bot.b);
    return o;
  endfunction

endpackage

// File: rtl/image_gaussian3x3_line_buffer.sv
// image_gaussian3x3_line_buffer: one-row RGB delay line on a shared
// address; the old word is read out in the cycle it is replaced.
module image_gaussian3x3_line_buffer
  import image_gaussian3x3_pkg::*;
#(
  parameter int DEPTH = 612,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [AW-1:0] i_addr,
  input  pix_t          i_wdata,
  output pix_t          o_rdata
);

  pix_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_en) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/image_gaussian3x3.sv
// image_gaussian3x3: streaming 3x3 Gaussian smoothing of raster RGB
// pixels with border passthrough and an end-of-frame flush.
module image_gaussian3x3
  import image_gaussian3x3_pkg::*;
#(
  parameter int WIDTH  = 612,
  parameter int HEIGHT = 408
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_R,
  input  logic [7:0] in_G,
  input  logic [7:0] in_B,
  output logic       out_valid,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       frame_done
);

  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [AW-1:0] COL_LAST = AW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [FW-1:0] FL_LAST  = FW'(WIDTH);

  state_t        r_state;
  logic [AW-1:0] r_col;
  logic [AW-1:0] r_ccol;
  logic [RW-1:0] r_row;
  logic [RW-1:0] r_crow;
  logic [FW-1:0] r_fcnt;
  col_t          r_w1;
  col_t          r_w2;
  pix_t          r_out;
  logic          r_out_valid;
  logic          r_frame_done;

  logic          w_run;
  logic          w_step;
  logic          w_emit;
  logic          w_in_last;
  logic          w_c_last;
  logic          w_border;
  logic [AW-1:0] w_addr;
  pix_t          w_din;
  pix_t          w_lb0;
  pix_t          w_lb1;
  col_t          w_new;

  assign w_run  = (r_state == S_RUN);
  assign w_step = w_run ? in_valid : 1'b1;
  assign w_din  = w_run ? {in_R, in_G, in_B} : '0;
  assign w_addr = w_run ? r_col :
                  (r_fcnt == FL_LAST) ? '0 : r_fcnt[AW-1:0];

  assign w_new = '{top: w_lb1, mid: w_lb0, bot: w_din};

  assign w_in_last = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_c_last  = (r_crow == ROW_LAST) && (r_ccol == COL_LAST);
  assign w_border  = (r_crow == '0) || (r_crow == ROW_LAST) ||
                     (r_ccol == '0) || (r_ccol == COL_LAST);

  // A full window exists once raster index W+1 has been accepted.
  assign w_emit = w_step && (!w_run || r_row >= RW'(2) ||
                  (r_row == RW'(1) && r_col != '0));

  image_gaussian3x3_line_buffer #(.DEPTH(WIDTH), .AW(AW)) u_lb0 (
    .clk     (clk),
    .i_en    (w_step),
    .i_addr  (w_addr),
    .i_wdata (w_din),
    .o_rdata (w_lb0)
  );

  image_gaussian3x3_line_buffer #(.DEPTH(WIDTH), .AW(AW)) u_lb1 (
    .clk     (clk),
    .i_en    (w_step),
    .i_addr  (w_addr),
    .i_wdata (w_lb0),
    .o_rdata (w_lb1)
  );

  always_ff @(posedge clk) begin
    if (w_step) begin
      r_w1 <= r_w2;
      r_w2 <= w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_RUN;
      r_row        <= '0;
      r_col        <= '0;
      r_fcnt       <= '0;
      r_crow       <= '0;
      r_ccol       <= '0;
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= w_emit;
      r_frame_done <= w_emit && w_c_last;
      if (w_emit) begin
        r_out <= w_border ? r_w2.mid : gauss_pix(r_w1, r_w2, w_new);
        if (r_ccol == COL_LAST) begin
          r_ccol <= '0;
          r_crow <= (r_crow == ROW_LAST) ? '0 : r_crow + 1'b1;
        end else begin
          r_ccol <= r_ccol + 1'b1;
        end
      end
      unique case (r_state)
        S_RUN: begin
          if (in_valid) begin
            if (r_col == COL_LAST) begin
              r_col <= '0;
              r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
            if (w_in_last) r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (r_fcnt == FL_LAST) begin
            r_fcnt  <= '0;
            r_state <= S_RUN;
          end else begin
            r_fcnt <= r_fcnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign in_ready   = w_run;
  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;
  assign R          = r_out.r;
  assign G          = r_out.g;
  assign B          = r_out.b;

endmodule

// File: tb/tb_image_gaussian3x3.sv
// tb_image_gaussian3x3: directed frames on a 4x3 image checked against
// hand tables and a coordinate-based Gaussian reference.
module tb_image_gaussian3x3;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } px_t;

  typedef struct {
    px_t din;
    px_t dexp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_R = '0;
  logic [7:0] in_G = '0;
  logic [7:0] in_B = '0;
  logic       in_ready;
  logic       out_valid;
  logic       frame_done;
  logic [7:0] R;
  logic [7:0] G;
  logic [7:0] B;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int lowrun = 0;

  px_t  img [2*N];
  px_t  exp_px [2*N];
  vec_t tbl [3][N];

  px_t cap_q [$];
  int  cyc_q [$];
  int  done_q [$];
  int  low_q [$];

  image_gaussian3x3 #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_R       (in_R),
    .in_G       (in_G),
    .in_B       (in_B),
    .out_valid  (out_valid),
    .R          (R),
    .G          (G),
    .B          (B),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (out_valid) begin
      cap_q.push_back({R, G, B});
      cyc_q.push_back(cyc);
      if (frame_done) done_q.push_back(cap_q.size());
    end else if (frame_done) begin
      done_q.push_back(-1);
    end
    if (!rst && !in_ready) begin
      lowrun++;
    end else if (lowrun > 0) begin
      low_q.push_back(lowrun);
      lowrun = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, want);
  endtask

  function automatic px_t ref_px(int base, int r, int c);
    int s [3];
    px_t p;
    px_t o;
    if (r == 0 || r == H-1 || c == 0 || c == W-1)
      return img[base + r*W + c];
    s = '{0, 0, 0};
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int wt;
        wt = (2 - (dr < 0 ? -dr : dr)) * (2 - (dc < 0 ? -dc : dc));
        p = img[base + (r+dr)*W + c + dc];
        s[0] += wt * int'(p.r);
        s[1] += wt * int'(p.g);
        s[2] += wt * int'(p.b);
      end
    end
    o.r = 8'(s[0] / 16);
    o.g = 8'(s[1] / 16);
    o.b = 8'(s[2] / 16);
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int base, input int gap, input int npix);
    for (int k = 0; k < npix; k++) begin
      int t;
      t = 0;
      in_valid = 1'b1;
      {in_R, in_G, in_B} = img[base + k];
      while (!in_ready && t < 50) begin
        tick();
        t++;
      end
      if (!in_ready) begin
        n_chk++;
        $display("FAIL send_timeout: in_ready 0 want 1 at pixel %0d", k);
      end
      tick();
      in_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic clear_q();
    cap_q.delete();
    cyc_q.delete();
    done_q.delete();
    low_q.delete();
  endtask

  task automatic check_frames(input string nm, input int nfr);
    int t;
    int tot;
    t = 0;
    tot = N * nfr;
    while (cap_q.size() < tot && t < 400) begin
      tick();
      t++;
    end
    repeat (W + 4) tick();
    chk({nm, "_count"}, cap_q.size(), tot);
    for (int j = 0; j < tot; j++)
      if (j < cap_q.size())
        chk($sformatf("%s_px%0d", nm, j), cap_q[j], exp_px[j]);
    chk({nm, "_done_n"}, done_q.size(), nfr);
    for (int f = 0; f < nfr; f++)
      if (f < done_q.size())
        chk($sformatf("%s_done_pos%0d", nm, f), done_q[f], N*(f+1));
  endtask

  task automatic load_table(input int t);
    for (int k = 0; k < N; k++) begin
      img[k]    = tbl[t][k].din;
      exp_px[k] = tbl[t][k].dexp;
    end
  endtask

  initial begin
    string tname [3];
    bit sp_ok;
    tname = '{"impulse", "uniform100", "sat255"};
    for (int k = 0; k < N; k++) begin
      tbl[0][k] = '{din: '0, dexp: '0};
      tbl[1][k] = '{din: {8'd100, 8'd100, 8'd100},
                    dexp: {8'd100, 8'd100, 8'd100}};
      tbl[2][k] = '{din: {8'd255, 8'd255, 8'd255},
                    dexp: {8'd255, 8'd255, 8'd255}};
    end
    tbl[0][5].din  = {8'd160, 8'd0, 8'd0};
    tbl[0][5].dexp = {8'd40, 8'd0, 8'd0};
    tbl[0][6].dexp = {8'd20, 8'd0, 8'd0};

    rst = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_rgb", {R, G, B}, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    tick();

    for (int t = 0; t < 3; t++) begin
      clear_q();
      load_table(t);
      send_frame(0, 0, N);
      check_frames(tname[t], 1);
      chk({tname[t], "_flush_low"}, (low_q.size() > 0) ? low_q[0] : 0,
          W + 1);
    end

    clear_q();
    load_table(0);
    send_frame(0, 1, N);
    check_frames("impulse_gap", 1);
    sp_ok = (cyc_q.size() == N);
    for (int j = 0; j + 1 < cyc_q.size(); j++) begin
      if (j < N - W - 2) sp_ok &= (cyc_q[j+1] - cyc_q[j] == 2);
      else sp_ok &= (cyc_q[j+1] - cyc_q[j] == 1);
    end
    chk("impulse_gap_spacing", sp_ok, 1);

    clear_q();
    for (int k = 0; k < N; k++) begin
      img[k]    = {8'd50, 8'd50, 8'd50};
      exp_px[k] = {8'd50, 8'd50, 8'd50};
    end
    send_frame(0, 0, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("abort_no_out", cap_q.size(), 0);
    chk("abort_in_ready", in_ready, 1);
    clear_q();
    send_frame(0, 0, N);
    check_frames("after_rst50", 1);

    clear_q();
    for (int k = 0; k < 2*N; k++) img[k] = px_t'($urandom);
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          exp_px[f*N + r*W + c] = ref_px(f*N, r, c);
    send_frame(0, 0, N);
    send_frame(N, 0, N);
    check_frames("b2b", 2);
    chk("b2b_low_n", low_q.size(), 2);
    for (int i = 0; i < 2; i++)
      if (i < low_q.size())
        chk($sformatf("b2b_low%0d", i), low_q[i], W + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
